// File: rtl/add_cmp_stage.sv
// rtl/add_cmp_stage.sv - registered adder post-processing stage: ALU result, branch decision, NZCV flags
// Two-entry skid buffer on the output plus a saturating taken-branch counter.
module add_cmp_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_sum,
    input  logic             in_v,
    input  logic             in_cout,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_taken,
    output logic [3:0]       out_flags,
    output logic             out_illegal,
    output logic [4:0]       out_rd,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef struct packed {
        logic [31:0] result;
        logic        taken;
        logic [3:0]  flags;
        logic        illegal;
        logic [4:0]  rd;
    } entry_t;

    entry_t main_q, skid_q, in_entry;
    logic   main_valid, skid_valid;
    logic   accept, drain;
    logic   flag_n, flag_z, lt, ltu;

    assign flag_n = in_sum[31];
    assign flag_z = (in_sum == 32'd0);
    assign lt     = flag_n ^ in_v;
    assign ltu    = ~in_cout;

    always_comb begin
        in_entry         = '0;
        in_entry.result  = in_sum;
        in_entry.flags   = {flag_n, flag_z, in_cout, in_v};
        in_entry.rd      = in_rd;
        case (in_op)
            4'd0, 4'd1: ;
            4'd2: in_entry.result = {31'b0, lt};
            4'd3: in_entry.result = {31'b0, ltu};
            4'd4: in_entry.taken  = flag_z;
            4'd5: in_entry.taken  = ~flag_z;
            4'd6: in_entry.taken  = lt;
            4'd7: in_entry.taken  = ~lt;
            4'd8: in_entry.taken  = ltu;
            4'd9: in_entry.taken  = ~ltu;
            default: in_entry.illegal = 1'b1;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign drain  = main_valid & out_ready;

    // in_ready mirrors ~skid_valid, so an accept never coincides with a full skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (drain && skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (!main_valid || drain) begin
            if (accept)
                main_q <= in_entry;
            main_valid <= accept;
        end else if (accept) begin
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            taken_cnt <= '0;
        else if (cnt_clr)
            taken_cnt <= '0;
        else if (drain && main_q.taken && taken_cnt != {CNT_W{1'b1}})
            taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign out_valid   = main_valid;
    assign out_result  = main_q.result;
    assign out_taken   = main_q.taken;
    assign out_flags   = main_q.flags;
    assign out_illegal = main_q.illegal;
    assign out_rd      = main_q.rd;

endmodule

// File: tb/tb_add_cmp_stage.sv
// tb/tb_add_cmp_stage.sv - self-checking bench for add_cmp_stage
module tb_add_cmp_stage;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_sum;
    logic        in_v, in_cout;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_taken;
    logic [3:0]  out_flags;
    logic        out_illegal;
    logic [4:0]  out_rd;
    logic        cnt_clr;
    logic [15:0] taken_cnt;

    add_cmp_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_sum(in_sum), .in_v(in_v), .in_cout(in_cout), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_taken(out_taken), .out_flags(out_flags),
        .out_illegal(out_illegal), .out_rd(out_rd),
        .cnt_clr(cnt_clr), .taken_cnt(taken_cnt)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] sum;
        logic        v;
        logic        cout;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        taken;
        logic [3:0]  flags;
        logic        illegal;
    } vec_t;

    vec_t        vecs[13];
    vec_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_cnt = 16'd0;
    bit          accepted, drained, seen_valid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] sum, input logic v,
                                input logic cout, input logic [4:0] rd, input logic [31:0] result,
                                input logic taken, input logic [3:0] flags, input logic illegal);
        vec_t t;
        t.op = op; t.sum = sum; t.v = v; t.cout = cout; t.rd = rd;
        t.result = result; t.taken = taken; t.flags = flags; t.illegal = illegal;
        return t;
    endfunction

    // One clock: drive at negedge, settle, score the handshakes, then check the counter after the edge.
    task automatic cycle(input bit valid, input vec_t t, input bit ordy, input bit clr);
        vec_t e;
        @(negedge clk);
        in_valid  = valid;
        out_ready = ordy;
        cnt_clr   = clr;
        if (valid) begin
            in_op = t.op; in_sum = t.sum; in_v = t.v; in_cout = t.cout; in_rd = t.rd;
        end else begin
            in_op = 'x; in_sum = 'x; in_v = 'x; in_cout = 'x; in_rd = 'x;
        end
        #1;
        accepted   = in_valid & in_ready;
        drained    = out_valid & out_ready;
        seen_valid = out_valid;
        if (drained) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'(out_rd), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("out_rd", 64'(out_rd), 64'(e.rd));
                chk("out_result", 64'(out_result), 64'(e.result));
                chk("out_taken", 64'(out_taken), 64'(e.taken));
                chk("out_flags", 64'(out_flags), 64'(e.flags));
                chk("out_illegal", 64'(out_illegal), 64'(e.illegal));
                if (!clr && e.taken && exp_cnt != 16'hFFFF)
                    exp_cnt = exp_cnt + 16'd1;
            end
        end
        if (clr)
            exp_cnt = 16'd0;
        if (accepted)
            exp_q.push_back(t);
        @(posedge clk);
        #1;
        chk("taken_cnt", 64'(taken_cnt), 64'(exp_cnt));
    endtask

    task automatic flush();
        vec_t idle;
        idle = vecs[0];
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            cycle(1'b0, idle, 1'b1, 1'b0);
        chk("flush_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        vec_t t;
        int   tries;

        vecs[0]  = mk(4'd2,  32'hFFFFFFFE, 1'b0, 1'b0, 5'd1,  32'd1,        1'b0, 4'b1000, 1'b0);
        vecs[1]  = mk(4'd3,  32'hFFFFFFFE, 1'b0, 1'b0, 5'd2,  32'd1,        1'b0, 4'b1000, 1'b0);
        vecs[2]  = mk(4'd2,  32'h80000000, 1'b1, 1'b0, 5'd3,  32'd0,        1'b0, 4'b1001, 1'b0);
        vecs[3]  = mk(4'd4,  32'h00000000, 1'b0, 1'b1, 5'd4,  32'd0,        1'b1, 4'b0110, 1'b0);
        vecs[4]  = mk(4'd5,  32'h00000000, 1'b0, 1'b1, 5'd5,  32'd0,        1'b0, 4'b0110, 1'b0);
        vecs[5]  = mk(4'd0,  32'h12345678, 1'b0, 1'b0, 5'd6,  32'h12345678, 1'b0, 4'b0000, 1'b0);
        vecs[6]  = mk(4'd1,  32'h00000000, 1'b0, 1'b1, 5'd7,  32'd0,        1'b0, 4'b0110, 1'b0);
        vecs[7]  = mk(4'd6,  32'hFFFFFFFE, 1'b0, 1'b0, 5'd8,  32'hFFFFFFFE, 1'b1, 4'b1000, 1'b0);
        vecs[8]  = mk(4'd7,  32'hFFFFFFFE, 1'b0, 1'b0, 5'd9,  32'hFFFFFFFE, 1'b0, 4'b1000, 1'b0);
        vecs[9]  = mk(4'd8,  32'h00000005, 1'b0, 1'b1, 5'd10, 32'd5,        1'b0, 4'b0010, 1'b0);
        vecs[10] = mk(4'd9,  32'h00000005, 1'b0, 1'b1, 5'd11, 32'd5,        1'b1, 4'b0010, 1'b0);
        vecs[11] = mk(4'd12, 32'hDEADBEEF, 1'b1, 1'b1, 5'd12, 32'hDEADBEEF, 1'b0, 4'b1011, 1'b1);
        vecs[12] = mk(4'd3,  32'h00000001, 1'b0, 1'b1, 5'd13, 32'd0,        1'b0, 4'b0010, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        in_op = 4'd0; in_sum = 32'd0; in_v = 1'b0; in_cout = 1'b0; in_rd = 5'd0;
        #22;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_taken_cnt", 64'(taken_cnt), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        chk("rst_out_misc", 64'({out_taken, out_illegal, out_rd}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streamed table vectors at full rate.
        for (int i = 0; i < 13; i++)
            cycle(1'b1, vecs[i], 1'b1, 1'b0);
        flush();
        chk("cnt_after_table", 64'(taken_cnt), 64'd3);

        // Backpressure: the third push is held upstream.
        for (int i = 1; i <= 3; i++) begin
            t = vecs[5]; t.rd = 5'(i);
            cycle(1'b1, t, 1'b0, 1'b0);
            chk($sformatf("bp_accept_%0d", i), 64'(accepted), (i == 3) ? 64'd0 : 64'd1);
        end
        chk("bp_hold_rd", 64'(out_rd), 64'd1);
        t = vecs[5]; t.rd = 5'd3;
        tries = 0;
        do begin
            cycle(1'b1, t, 1'b1, 1'b0);
            chk("bp_stream_valid", 64'(seen_valid), 64'd1);
            tries++;
        end while (!accepted && tries < 5);
        chk("bp_rd3_accepted", 64'(accepted), 64'd1);
        cycle(1'b0, t, 1'b1, 1'b0);
        chk("bp_stream_valid_last", 64'(seen_valid), 64'd1);
        flush();

        // Saturation of the taken counter, then clear racing a taken drain.
        for (int i = 0; i < 65536; i++)
            cycle(1'b1, vecs[3], 1'b1, 1'b0);
        flush();
        chk("cnt_saturated", 64'(taken_cnt), 64'hFFFF);
        cycle(1'b1, vecs[3], 1'b1, 1'b0);
        cycle(1'b0, vecs[3], 1'b1, 1'b1);
        chk("cnt_clr_priority", 64'(taken_cnt), 64'd0);
        chk("cnt_clr_drained", 64'(drained), 64'd1);

        // Asynchronous reset with both entries full.
        cycle(1'b1, vecs[0], 1'b0, 1'b0);
        cycle(1'b1, vecs[1], 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        exp_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        t = vecs[11]; t.rd = 5'd21;
        cycle(1'b1, t, 1'b0, 1'b0);
        chk("post_rst_accept", 64'(accepted), 64'd1);
        chk("post_rst_latency", 64'(out_valid), 64'd1);
        cycle(1'b0, t, 1'b1, 1'b0);
        chk("post_rst_drain", 64'(drained), 64'd1);
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_cmp_stage.md
Name: add_cmp_stage

Overview:
- Registered stage directly downstream of the 32-bit carry-select adder/subtractor (operands A, B, cin; results sum, V, cout).
- Turns raw adder results into the RISC-V ALU result for ADD/SUB/SLT/SLTU, a branch-taken decision for BEQ/BNE/BLT/BGE/BLTU/BGEU, and an NZCV flag vector.
- Two-entry skid buffer with valid/ready handshakes on both sides, so the EX stage runs at full throughput under backpressure.
- Also keeps a saturating taken-branch counter.

Parameters:
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; driven directly from a register.
- in_op  in  4  operation code, see Behaviour.
- in_sum  in  32  adder sum.
- in_v  in  1  adder signed overflow.
- in_cout  in  1  adder carry-out; for subtract, 1 means no borrow (A >= B unsigned).
- in_rd  in  5  destination register tag, passed through.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_result  out  32  ALU result.
- out_taken  out  1  branch taken.
- out_flags  out  4  {N,Z,C,V}.
- out_illegal  out  1  in_op was undefined.
- out_rd  out  5  passed-through tag.
- cnt_clr  in  1  synchronous clear of the taken counter.
- taken_cnt  out  CNT_W  taken-branch count.

Behaviour:
- Flags, computed at the input and registered with the entry:
  - N = in_sum[31]; Z = (in_sum == 0); C = in_cout; V = in_v.
  - Let LT = N^V and LTU = ~C.
- in_op decode:
  - 0 ADD, 1 SUB: result = sum, taken = 0.
  - 2 SLT: result = {31'b0, LT}. 3 SLTU: result = {31'b0, LTU}. taken = 0.
  - 4 BEQ: taken = Z. 5 BNE: taken = ~Z. 6 BLT: taken = LT. 7 BGE: taken = ~LT. 8 BLTU: taken = LTU. 9 BGEU: taken = ~LTU.
  - For ops 4-9: result = sum.
  - Ops 10-15: result = sum, taken = 0, illegal = 1. Illegal entries still flow through normally.
- Storage: main register (drives the out_* ports) and skid register, each with its own valid bit. out_valid = main_valid.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Per-cycle update:
  - Main empty, or draining with skid empty: an accepted entry loads main.
  - Draining with skid valid: skid moves to main. An accepted entry that cycle loads skid.
  - Main valid, not draining: an accepted entry loads skid.
  - in_ready next = ~skid_valid next. Accept is never allowed with both registers full.
- Latency: 1 cycle from accept to out_valid when empty. Order is strictly FIFO. Throughput is 1 entry/cycle with out_ready held high.
- Output payload stays stable while out_valid=1 and out_ready=0.
- taken_cnt:
  - Increments on Drain when out_taken=1; saturates at all-ones.
  - cnt_clr has priority: count becomes 0 that cycle, and an increment in the same cycle is discarded.
- Reset, including mid-operation:
  - Both valid bits 0, in_ready=1, taken_cnt=0.
  - out_result, out_flags, out_taken, out_illegal and out_rd all reset to 0.
  - In-flight entries are dropped.
- Undriven or X in_op while in_valid=0 has no effect on state.

Test Plan:
- SUB 5-7 (sum=0xFFFFFFFE, cout=0, V=0):
  - op SLT → result=1, flags=4'b1000.
  - op SLTU → result=1.
- SLT 0x7FFFFFFF-0xFFFFFFFF (sum=0x80000000, V=1, cout=0) → LT=0, result=0, flags=4'b1001.
- BEQ with sum=0, cout=1 → taken=1, flags=4'b0110. BNE same inputs → taken=0. Check taken_cnt increments by 1 only for BEQ on drain.
- Backpressure: out_ready=0, push rd=1,2,3 on consecutive cycles.
  - in_ready falls after the 2nd accept; rd=3 is held upstream.
  - Raise out_ready → outputs rd=1,2,3 in order, with no gaps once streaming.
- Op 12 → out_illegal=1, taken=0, result=sum.
- Saturation: preload taken_cnt to 0xFFFF via 65535 taken branches, then one more → stays 0xFFFF. cnt_clr with a taken drain in the same cycle → 0.
- Reset asserted with both entries full → out_valid=0, in_ready=1 immediately (asynchronous); after release, the next accept appears 1 cycle later.
